// File: rtl/shift_add_mul_pkg.sv
// Shared types and helpers for the shift-add multiply / multiply-accumulate sequencer.
package shift_add_mul_pkg;

    // Sequencer states: waiting for a request, iterating, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Request opcodes.
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_MAC = 1'b1;

    // Width of the step counter: it only has to reach W-1.
    // Clamped to one bit so the counter never collapses to zero width.
    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/shift_add_mul_dp.sv
// Private datapath: Acc / MQ / DR registers, conditional adder and the
// combined right shift of {carry, Acc, MQ}. One iteration per asserted step.
module shift_add_mul_dp
    import shift_add_mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic           load_op,
    input  logic [W-1:0]   load_a,
    input  logic [W-1:0]   load_b,
    input  logic [W-1:0]   load_c,
    output logic [2*W-1:0] prod
);

    logic [W-1:0] acc_reg;
    logic [W-1:0] mq_reg;
    logic [W-1:0] dr_reg;
    logic [W-1:0] addend;
    logic [W:0]   sum;

    // The multiplicand is added only when the current multiplier bit is set.
    for (genvar gi = 0; gi < W; gi++) begin : g_addend
        assign addend[gi] = dr_reg[gi] & mq_reg[0];
    end

    // W+1 bits so the carry is kept; it becomes the new Acc MSB after the shift.
    assign sum = {1'b0, acc_reg} + {1'b0, addend};

    // Operand load on acceptance, otherwise one add-and-shift per step.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_reg <= '0;
            mq_reg  <= '0;
            dr_reg  <= '0;
        end else if (load) begin
            dr_reg  <= load_a;
            mq_reg  <= load_b;
            // MAC seeds Acc with the addend; after W shifts it lands in the low half.
            acc_reg <= (load_op == OP_MAC) ? load_c : '0;
        end else if (step) begin
            acc_reg <= sum[W:1];
            mq_reg  <= {sum[0], mq_reg[W-1:1]};
        end
    end

    // The result is the register pair itself, so it holds between operations.
    assign prod = {acc_reg, mq_reg};

endmodule

// File: rtl/shift_add_mul_seq.sv
// Sequencer for multi-cycle unsigned multiply / multiply-accumulate.
// Owns the FSM, step counter and both valid/ready handshakes; the arithmetic
// lives in shift_add_mul_dp. Fixed latency of W iterations, no early exit.
module shift_add_mul_seq
    import shift_add_mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_op,
    input  logic [W-1:0]   req_a,
    input  logic [W-1:0]   req_b,
    input  logic [W-1:0]   req_c,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*W-1:0] rsp_prod,
    output logic           busy
);

    localparam int             CW       = cnt_w(W);
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] cnt_reg;
    logic          load;
    logic          step;
    logic          last_step;

    assign last_step = (cnt_reg == CNT_LAST);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, W steps in ITER, wait for the consumer in DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = ITER;
            ITER:    if (last_step) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs and datapath controls decoded from the current state.
    always_comb begin
        req_ready = (state_reg == IDLE);
        rsp_valid = (state_reg == DONE);
        busy      = (state_reg != IDLE);
        load      = (state_reg == IDLE) && req_valid;
        step      = (state_reg == ITER);
    end

    // Step counter; it stops at W-1 on the final step instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= '0;
        end else if (step && !last_step) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    shift_add_mul_dp #(
        .W (W)
    ) u_dp (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .load_op (req_op),
        .load_a  (req_a),
        .load_b  (req_b),
        .load_c  (req_c),
        .prod    (rsp_prod)
    );

endmodule

// File: tb/tb_shift_add_mul_seq.sv
// Directed bench for shift_add_mul_seq: a W=8 instance for the main scenarios
// and a W=4 instance for the narrow-width latency and carry cases.
module tb_shift_add_mul_seq;

    logic        clock;
    logic        reset;

    // W = 8 instance
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic [7:0]  req_c;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_prod;
    logic        busy;

    // W = 4 instance
    logic        req_valid4;
    logic        req_ready4;
    logic        req_op4;
    logic [3:0]  req_a4;
    logic [3:0]  req_b4;
    logic [3:0]  req_c4;
    logic        rsp_valid4;
    logic        rsp_ready4;
    logic [7:0]  rsp_prod4;
    logic        busy4;

    int n_cmp;
    int n_bad;

    shift_add_mul_seq #(.W(8)) dut8 (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .busy      (busy)
    );

    shift_add_mul_seq #(.W(4)) dut4 (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid4),
        .req_ready (req_ready4),
        .req_op    (req_op4),
        .req_a     (req_a4),
        .req_b     (req_b4),
        .req_c     (req_c4),
        .rsp_valid (rsp_valid4),
        .rsp_ready (rsp_ready4),
        .rsp_prod  (rsp_prod4),
        .busy      (busy4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Starting in cycle t+1 of a request accepted in cycle t, advance until
    // rsp_valid is seen; returns n such that rsp_valid first rose in cycle t+n
    // (0 if it never rose within the bound).
    task automatic wait_rsp8(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            if (rsp_valid === 1'b1) begin
                n = i;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic wait_rsp4(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            if (rsp_valid4 === 1'b1) begin
                n = i;
                break;
            end
            @(negedge clock);
        end
    endtask

    // Offer a request on the W=8 port in the current cycle, move into cycle t+1 and drop it.
    task automatic issue8(input logic op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_c     = c;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_cmp++; if (req_ready !== 1'b1)      begin n_bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0)      begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0)           begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (rsp_prod !== 16'h0000)   begin n_bad++; $display("FAIL reset_rsp_prod got=%h exp=0000", rsp_prod); end
        n_cmp++; if (rsp_prod4 !== 8'h00)     begin n_bad++; $display("FAIL reset_rsp_prod4 got=%h exp=00", rsp_prod4); end
        reset = 1'b0;
        @(negedge clock);
        $display("test_reset: outputs after reset checked");
    endtask

    task automatic test_mul_basic();
        rsp_ready = 1'b1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mul_req_ready_before got=%b exp=1", req_ready); end
        issue8(1'b0, 8'd13, 8'd11, 8'hEE);
        // Cycles t+1 .. t+8: still iterating.
        for (int i = 1; i <= 8; i++) begin
            n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
                n_bad++; $display("FAIL mul_iter_cycle%0d rsp_valid=%b busy=%b exp rsp_valid=0 busy=1", i, rsp_valid, busy);
            end
            @(negedge clock);
        end
        // Cycle t+9: result presented.
        n_cmp++; if (rsp_valid !== 1'b1)    begin n_bad++; $display("FAIL mul_latency rsp_valid=%b exp=1 at t+9", rsp_valid); end
        n_cmp++; if (rsp_prod !== 16'h008F) begin n_bad++; $display("FAIL mul_13x11 got=%h exp=008f", rsp_prod); end
        @(negedge clock);
        n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL mul_return_idle req_ready=%b busy=%b exp 1/0", req_ready, busy);
        end
        n_cmp++; if (rsp_prod !== 16'h008F) begin n_bad++; $display("FAIL mul_hold_in_idle got=%h exp=008f", rsp_prod); end
        $display("test_mul_basic: 13*11 -> %h", rsp_prod);
    endtask

    task automatic test_mac_carry();
        int n;
        rsp_ready = 1'b1;
        issue8(1'b1, 8'hFF, 8'hFF, 8'hFF);
        wait_rsp8(n);
        n_cmp++; if (n != 9)                begin n_bad++; $display("FAIL mac_latency got=%0d exp=9", n); end
        n_cmp++; if (rsp_prod !== 16'hFF00) begin n_bad++; $display("FAIL mac_ffxff_ff got=%h exp=ff00", rsp_prod); end
        @(negedge clock);
        $display("test_mac_carry: ff*ff+ff -> %h", rsp_prod);
    endtask

    task automatic test_stall();
        int n;
        rsp_ready = 1'b0;
        issue8(1'b0, 8'hA5, 8'h3C, 8'h00);
        // Pulse a conflicting request mid-iteration (cycle t+3).
        @(negedge clock);
        @(negedge clock);
        req_valid = 1'b1; req_op = 1'b1; req_a = 8'h01; req_b = 8'h01; req_c = 8'h01;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready_in_iter got=%b exp=0", req_ready); end
        @(negedge clock);
        req_valid = 1'b0;
        wait_rsp8(n);
        n_cmp++; if (n != 6) begin n_bad++; $display("FAIL stall_latency got=t+%0d exp=t+9", n + 3); end
        // Hold in DONE for 5 cycles with a request offered the whole time.
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_prod !== 16'h26AC || req_ready !== 1'b0 || busy !== 1'b1) begin
                n_bad++; $display("FAIL stall_hold%0d valid=%b prod=%h ready=%b busy=%b exp 1/26ac/0/1",
                                  i, rsp_valid, rsp_prod, req_ready, busy);
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clock);
        n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL stall_release valid=%b ready=%b exp 0/1", rsp_valid, req_ready);
        end
        n_cmp++; if (rsp_prod !== 16'h26AC) begin n_bad++; $display("FAIL stall_prod_after got=%h exp=26ac", rsp_prod); end
        $display("test_stall: a5*3c -> %h held through stall", rsp_prod);
    endtask

    task automatic test_back_to_back();
        int n;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = 1'b0; req_a = 8'd7; req_b = 8'd9; req_c = 8'h77;
        @(negedge clock);
        // Second request waits, held valid, while the first runs.
        req_op = 1'b1; req_a = 8'h00; req_b = 8'h55; req_c = 8'h2A;
        wait_rsp8(n);
        n_cmp++; if (n != 9)                begin n_bad++; $display("FAIL b2b_first_latency got=%0d exp=9", n); end
        n_cmp++; if (rsp_prod !== 16'h003F) begin n_bad++; $display("FAIL b2b_first_7x9 got=%h exp=003f", rsp_prod); end
        @(negedge clock);
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_accept_cycle ready=%b valid=%b exp 1/0", req_ready, rsp_valid);
        end
        @(negedge clock);
        req_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_started busy=%b exp=1", busy); end
        wait_rsp8(n);
        n_cmp++; if (n != 9)                begin n_bad++; $display("FAIL b2b_second_latency got=%0d exp=9", n); end
        n_cmp++; if (rsp_prod !== 16'h002A) begin n_bad++; $display("FAIL b2b_second_mac got=%h exp=002a", rsp_prod); end
        @(negedge clock);
        $display("test_back_to_back: 7*9 then 0*55+2a checked");
    endtask

    task automatic test_reset_mid();
        int n;
        rsp_ready = 1'b1;
        issue8(1'b0, 8'hFF, 8'hFF, 8'h00);
        // cnt is 0 in t+1, reaches 4 in t+5.
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL midreset_idle busy=%b ready=%b valid=%b exp 0/1/0", busy, req_ready, rsp_valid);
        end
        n_cmp++; if (rsp_prod !== 16'h0000) begin n_bad++; $display("FAIL midreset_prod got=%h exp=0000", rsp_prod); end
        issue8(1'b0, 8'h80, 8'h02, 8'h00);
        wait_rsp8(n);
        n_cmp++; if (n != 9)                begin n_bad++; $display("FAIL midreset_latency got=%0d exp=9", n); end
        n_cmp++; if (rsp_prod !== 16'h0100) begin n_bad++; $display("FAIL midreset_80x02 got=%h exp=0100", rsp_prod); end
        @(negedge clock);
        $display("test_reset_mid: aborted op, then 80*02 -> %h", rsp_prod);
    endtask

    task automatic test_w4();
        int n;
        rsp_ready4 = 1'b1;
        req_valid4 = 1'b1; req_op4 = 1'b0; req_a4 = 4'hF; req_b4 = 4'hF; req_c4 = 4'h3;
        @(negedge clock);
        req_valid4 = 1'b0;
        wait_rsp4(n);
        n_cmp++; if (n != 5)              begin n_bad++; $display("FAIL w4_mul_latency got=%0d exp=5", n); end
        n_cmp++; if (rsp_prod4 !== 8'hE1) begin n_bad++; $display("FAIL w4_mul_fxf got=%h exp=e1", rsp_prod4); end
        @(negedge clock);
        req_valid4 = 1'b1; req_op4 = 1'b1; req_a4 = 4'hF; req_b4 = 4'hF; req_c4 = 4'hF;
        @(negedge clock);
        req_valid4 = 1'b0;
        wait_rsp4(n);
        n_cmp++; if (n != 5)              begin n_bad++; $display("FAIL w4_mac_latency got=%0d exp=5", n); end
        n_cmp++; if (rsp_prod4 !== 8'hF0) begin n_bad++; $display("FAIL w4_mac_fxf_f got=%h exp=f0", rsp_prod4); end
        @(negedge clock);
        $display("test_w4: f*f and f*f+f checked");
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        req_valid  = 1'b0; req_op  = 1'b0; req_a  = '0; req_b  = '0; req_c  = '0; rsp_ready  = 1'b0;
        req_valid4 = 1'b0; req_op4 = 1'b0; req_a4 = '0; req_b4 = '0; req_c4 = '0; rsp_ready4 = 1'b0;
        @(negedge clock);
        test_reset();
        test_mul_basic();
        test_mac_carry();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_w4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
